aes_round_ctrl: RTL and testbench

//   Iterative AES round sequencer. Accepts one 128-bit block per handshake and drives a shared

---
 rtl/aes_round_ctrl.sv | 118 +++++++++++
 tb/tb_aes_round_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: holds the block state, steps a shared round
// datapath through NR+1 passes, and presents the finished block downstream.
module aes_round_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned DW = 128,
  localparam int unsigned RW = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_inv,
  input  logic          rk_valid,
  output logic [RW-1:0] rk_idx,
  output logic [DW-1:0] rnd_state,
  output logic          rnd_inv,
  output logic          rnd_first,
  output logic          rnd_last,
  input  logic [DW-1:0] rnd_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [DW-1:0] data_q, data_d;
  logic          mode_q, mode_d;

  // State, round counter, block register and mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    data_d    = data_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_inv;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // A missing round key stalls everything; the round only advances with a key.
        if (rk_valid) begin
          data_d = rnd_result;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RW'(1);
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // IDLE is always visited between blocks, so no accept happens here.
        if (out_ready) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // Datapath controls decoded from the round counter; DONE keeps the last pass values.
  always_comb begin
    rnd_first = 1'b0;
    rnd_last  = 1'b0;
    rk_idx    = '0;
    if (state_q != IDLE) begin
      rnd_first = (round_q == '0);
      rnd_last  = (round_q == LAST_ROUND);
      rk_idx    = mode_q ? (LAST_ROUND - round_q) : round_q;
    end
  end

  assign rnd_state = data_q;
  assign out_data  = data_q;
  assign rnd_inv   = mode_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: golden AES round datapath and key schedule,
// FIPS-197 vectors, stall/hold/reset/back-to-back sequences, random blocks.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;
  localparam int unsigned DW = 128;
  localparam int unsigned RW = $clog2(NR + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_inv;
  logic          rk_valid;
  logic [RW-1:0] rk_idx;
  logic [DW-1:0] rnd_state;
  logic          rnd_inv;
  logic          rnd_first;
  logic          rnd_last;
  logic [DW-1:0] rnd_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  aes_round_ctrl #(.NR(NR), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rnd_state(rnd_state), .rnd_inv(rnd_inv), .rnd_first(rnd_first), .rnd_last(rnd_last),
    .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rks   [0:NR];

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_of(input int a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = 8'(a);
    for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        src = inv ? (c - w + 4) % 4 : (c + w) % 4;
        r[127-8*(c*4+w) -: 8] = s[127-8*(src*4+w) -: 8];
      end
    return r;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int k);
    case (k)
      0: return inv ? 8'h0e : 8'h02;
      1: return inv ? 8'h0b : 8'h03;
      2: return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0] acc;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef(inv, (j - w + 4) % 4), s[127-8*(c*4+j) -: 8]);
        r[127-8*(c*4+w) -: 8] = acc;
      end
    return r;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Whole-cipher reference using the currently loaded key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] din, input logic inv);
    logic [127:0] s;
    if (!inv) begin
      s = din ^ rks[0];
      for (int r = 1; r <= NR; r++) begin
        s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (r < NR) s = mix(s, 1'b0);
        s = s ^ rks[r];
      end
    end else begin
      s = din ^ rks[NR];
      for (int r = NR - 1; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rks[r];
        if (r > 0) s = mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  // One pass of the shared round datapath.
  function automatic logic [127:0] dp(input logic [127:0] s, input logic inv, input logic first,
                                      input logic last, input logic [127:0] rk);
    logic [127:0] r;
    if (first) return s ^ rk;
    if (!inv) begin
      r = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!last) r = mix(r, 1'b0);
      return r ^ rk;
    end
    r = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk;
    if (!last) r = mix(r, 1'b1);
    return r;
  endfunction

  logic [127:0] cur_rk;
  always_comb begin
    cur_rk = (int'(rk_idx) <= NR) ? rks[rk_idx] : '0;
    rnd_result = dp(rnd_state, rnd_inv, rnd_first, rnd_last, cur_rk);
  end

  // ---------------- bench utilities ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Run one block through the controller, checking controls each cycle.
  task automatic do_block(input logic [127:0] din, input logic inv, input logic [127:0] exp,
                          input int stall_at, input int stall_len, input int stall_pct,
                          input int hold, input int abort_at);
    int p, cyc, sc, k;
    logic adv;
    logic [7:0] ectl;
    logic [127:0] prev;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    chk("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = din;
    in_inv   = inv;
    rk_valid = 1'b0;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inv   = ~inv;
    chk("after_accept busy/in_ready/out_valid", 128'({busy, in_ready, out_valid}), 128'(3'b100));
    p = 0;
    cyc = 0;
    sc = 0;
    while (p <= NR && cyc < 100) begin
      ectl = {1'b0, (p == 0), (p == NR), inv, 4'(inv ? NR - p : p)};
      chk("run ctl ov/first/last/inv/rk_idx",
          128'({out_valid, rnd_first, rnd_last, rnd_inv, 4'(rk_idx)}), 128'(ectl));
      if (p == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_abort rdy/ov/busy/first/last/rk",
            128'({in_ready, out_valid, busy, rnd_first, rnd_last, 4'(rk_idx)}),
            128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}));
        return;
      end
      adv = 1'b1;
      if (p == stall_at && sc < stall_len) begin
        adv = 1'b0;
        sc++;
      end else if (int'($urandom_range(99, 0)) < stall_pct) begin
        adv = 1'b0;
      end
      rk_valid = adv;
      prev = rnd_state;
      step();
      rk_valid = 1'b0;
      cyc++;
      if (adv) p++;
      else chk("stall_frozen rnd_state", rnd_state, prev);
    end
    chk("done out_valid/busy/in_ready", 128'({out_valid, busy, in_ready}), 128'(3'b110));
    chk("out_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("hold out_valid/in_ready/busy", 128'({out_valid, in_ready, busy}), 128'(3'b101));
      chk("hold out_data", out_data, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release out_valid/in_ready/busy", 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int accepts [$];
    int nf, nl, nout;
    logic [127:0] key, din, exp;
    logic inv;

    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               1'b1, 128'h00112233445566778899aabbccddeeff};
    tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               1'b0, 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
               1'b1, 128'h3243f6a8885a308d313198a2e0370734};

    for (int a = 0; a < 256; a++) begin
      sbox[a] = sbox_of(a);
      isbox[sbox[a]] = 8'(a);
    end
    set_key(tbl[0].key);

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_inv = 1'b0;
    rk_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset rdy/ov/busy/first/last/inv/rk",
        128'({in_ready, out_valid, busy, rnd_first, rnd_last, rnd_inv, 4'(rk_idx)}),
        128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}));
    chk("reset rnd_state", rnd_state, 128'h0);

    // FIPS-197 vectors, keys always available
    for (int i = 0; i < 4; i++) begin
      set_key(tbl[i].key);
      do_block(tbl[i].din, tbl[i].inv, tbl[i].exp, -1, 0, 0, 0, -1);
    end

    // key stall of 3 cycles at round 4
    set_key(tbl[0].key);
    do_block(tbl[0].din, 1'b0, tbl[0].exp, 4, 3, 0, 0, -1);

    // downstream holds off for 5 cycles with a new request pending
    do_block(tbl[1].din, 1'b1, tbl[1].exp, -1, 0, 0, 5, -1);

    // reset at round 6 aborts, then a clean block
    do_block(tbl[0].din, 1'b0, tbl[0].exp, -1, 0, 0, 0, 6);
    do_block(tbl[0].din, 1'b0, tbl[0].exp, -1, 0, 0, 0, -1);

    // back-to-back with valid and ready tied high
    in_valid = 1'b1;
    in_data = tbl[0].din;
    in_inv = 1'b0;
    rk_valid = 1'b1;
    out_ready = 1'b1;
    nf = 0;
    nl = 0;
    nout = 0;
    for (int c = 0; c < 3 * (NR + 3); c++) begin
      if (in_valid && in_ready) accepts.push_back(c);
      if (busy && !out_valid) begin
        nf += int'(rnd_first);
        nl += int'(rnd_last);
      end
      if (out_valid) begin
        nout++;
        chk("b2b out_data", out_data, tbl[0].exp);
      end
      step();
    end
    in_valid = 1'b0;
    rk_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b accept count", 128'(accepts.size()), 128'(3));
    for (int i = 1; i < accepts.size(); i++)
      chk("b2b accept spacing", 128'(accepts[i] - accepts[i-1]), 128'(NR + 3));
    chk("b2b first count", 128'(nf), 128'(3));
    chk("b2b last count", 128'(nl), 128'(3));
    chk("b2b output count", 128'(nout), 128'(3));
    chk("b2b idle after", 128'({busy, in_ready}), 128'(2'b01));

    // random blocks with random key stalls and downstream backpressure
    for (int t = 0; t < 20; t++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      din = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'($urandom_range(1, 0));
      set_key(key);
      exp = aes_ref(din, inv);
      do_block(din, inv, exp, -1, 0, 25, int'($urandom_range(3, 0)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
